// File: rtl/poly_voice_mixer.sv
// poly_voice_mixer: N-voice sample collector with a time-multiplexed saturating mixer.
// Optional per-voice gain is enabled with the POLY_MIXER_GAIN_EN macro.
module poly_voice_mixer #(
    parameter int NUM_VOICES    = 4,
    parameter int SAMPLE_WIDTH  = 16,
    parameter int READY_TIMEOUT = 64
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               new_frame,
    input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0] voice_samples,
    input  logic [NUM_VOICES-1:0]              voice_ready,
    input  logic [NUM_VOICES-1:0]              voice_active,
`ifdef POLY_MIXER_GAIN_EN
    input  logic [4*NUM_VOICES-1:0]            voice_gain,
`endif
    input  logic                               clip_clear,
    output logic                               generate_next_sample,
    output logic                               new_sample_generated,
    output logic [SAMPLE_WIDTH-1:0]            sample_out,
    output logic                               clip,
    output logic                               missed,
    output logic                               underrun
);

    localparam int W  = SAMPLE_WIDTH;
    localparam int AW = SAMPLE_WIDTH + 8;
    localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    localparam logic [IW-1:0] LAST = IW'(NUM_VOICES - 1);

    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_ACCUM = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]                  state_q, state_d;
    logic                        nf_q;
    logic [7:0]                  cnt_q, cnt_d;
    logic [IW-1:0]               idx_q, idx_d;
    logic [NUM_VOICES-1:0]       got_q, got_d;
    logic signed [W-1:0]         lat_q [NUM_VOICES];
    logic signed [W-1:0]         lat_d [NUM_VOICES];
    logic signed [AW-1:0]        acc_q, acc_d;
    logic [W-1:0]                pending_q, pending_d;
    logic [W-1:0]                sample_q, sample_d;
    logic                        pulse_q, pulse_d;
    logic                        clip_q, clip_d;
    logic                        missed_q, missed_d;
    logic                        under_q, under_d;

    logic                        frame_edge;
    logic [NUM_VOICES-1:0]       take;
    logic                        all_in;
    logic signed [W-1:0]         sel;
    logic                        sel_use;
    logic signed [AW-1:0]        term;
    logic                        clip_set;
    logic                        missed_set;
    logic                        under_set;

    assign frame_edge = new_frame & ~nf_q;
    assign take       = voice_ready & ~got_q;
    assign all_in     = &(got_q | ~voice_active);

`ifdef POLY_MIXER_GAIN_EN
    logic [3:0]          gsel;
    logic signed [W+4:0] prod;
`endif

    // Select the latched sample and its scaled contribution for the current voice index
    always_comb begin
        sel     = '0;
        sel_use = 1'b0;
`ifdef POLY_MIXER_GAIN_EN
        gsel    = 4'd0;
`endif
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (idx_q == IW'(i)) begin
                sel     = lat_q[i];
                sel_use = voice_active[i] & got_q[i];
`ifdef POLY_MIXER_GAIN_EN
                gsel    = voice_gain[i*4 +: 4];
`endif
            end
        end
`ifdef POLY_MIXER_GAIN_EN
        prod = sel * $signed({1'b0, gsel});
        term = sel_use ? AW'(prod >>> 3) : '0;
`else
        term = sel_use ? AW'(sel) : '0;
`endif
    end

    // Next-state logic: collect, accumulate, saturate; a frame edge overrides everything
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        got_d      = got_q;
        lat_d      = lat_q;
        acc_d      = acc_q;
        pending_d  = pending_q;
        sample_d   = sample_q;
        pulse_d    = 1'b0;
        clip_set   = 1'b0;
        missed_set = 1'b0;
        under_set  = 1'b0;

        case (state_q)
            ST_WAIT: begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (take[i]) begin
                        lat_d[i] = voice_samples[i*W +: W];
                        got_d[i] = 1'b1;
                    end
                end
                if (all_in) begin
                    state_d = ST_ACCUM;
                    idx_d   = '0;
                    acc_d   = '0;
                end else if (cnt_q == 8'd0) begin
                    state_d    = ST_ACCUM;
                    idx_d      = '0;
                    acc_d      = '0;
                    missed_set = |(voice_active & ~(got_q | take));
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_ACCUM: begin
                acc_d = acc_q + term;
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (acc_q > SAT_MAX) begin
                    pending_d = SAT_MAX[W-1:0];
                    clip_set  = 1'b1;
                end else if (acc_q < SAT_MIN) begin
                    pending_d = SAT_MIN[W-1:0];
                    clip_set  = 1'b1;
                end else begin
                    pending_d = acc_q[W-1:0];
                end
                state_d = ST_IDLE;
            end
            default: begin
            end
        endcase

        if (frame_edge) begin
            sample_d = pending_q;
            pulse_d  = 1'b1;
            got_d    = '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                lat_d[i] = '0;
            end
            cnt_d     = 8'(READY_TIMEOUT);
            idx_d     = '0;
            acc_d     = '0;
            state_d   = ST_WAIT;
            under_set = (state_q == ST_WAIT) || (state_q == ST_ACCUM);
        end

        clip_d   = clip_set   | (clip_q   & ~clip_clear);
        missed_d = missed_set | (missed_q & ~clip_clear);
        under_d  = under_set  | (under_q  & ~clip_clear);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            nf_q      <= 1'b0;
            cnt_q     <= '0;
            idx_q     <= '0;
            got_q     <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                lat_q[i] <= '0;
            end
            acc_q     <= '0;
            pending_q <= '0;
            sample_q  <= '0;
            pulse_q   <= 1'b0;
            clip_q    <= 1'b0;
            missed_q  <= 1'b0;
            under_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            nf_q      <= new_frame;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            got_q     <= got_d;
            lat_q     <= lat_d;
            acc_q     <= acc_d;
            pending_q <= pending_d;
            sample_q  <= sample_d;
            pulse_q   <= pulse_d;
            clip_q    <= clip_d;
            missed_q  <= missed_d;
            under_q   <= under_d;
        end
    end

    assign generate_next_sample = pulse_q;
    assign new_sample_generated = pulse_q;
    assign sample_out           = sample_q;
    assign clip                 = clip_q;
    assign missed               = missed_q;
    assign underrun             = under_q;

endmodule

// File: doc/poly_voice_mixer.md
# poly_voice_mixer

Parametrised N-voice sample collector and mixer that sits between the note players and the codec interface. It generalises the fixed three-voice, unscaled sum-and-condition path to `NUM_VOICES` voices. It uses a time-multiplexed saturating accumulator, a ready-collection handshake with a timeout, and optional per-voice gain. The mixed sample is presented to the codec synchronised to the `new_frame` rising edge, with one frame of latency.

## Interface
Parameters:
- `NUM_VOICES`, 4: number of voice inputs, 1..16.
- `SAMPLE_WIDTH`, 16: signed two's-complement sample width.
- `READY_TIMEOUT`, 64: cycles to wait for voice-ready before substituting zero, 2..255.

Ports:
- `clk`  in  1  system clock. One clock domain only.
- `reset`  in  1  synchronous, active-high reset.
- `new_frame`  in  1  raw codec frame level; the block edge-detects it internally.
- `voice_samples`  in  `NUM_VOICES*SAMPLE_WIDTH`  flat signed samples; voice i occupies bits `[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]`.
- `voice_ready`  in  `NUM_VOICES`  per-voice pulse: the sample is valid this cycle.
- `voice_active`  in  `NUM_VOICES`  mask; inactive voices contribute 0 and are not waited on.
- `voice_gain`  in  `4*NUM_VOICES`  per-voice unsigned gain, 8 = unity. Present only with `POLY_MIXER_GAIN_EN`.
- `clip_clear`  in  1  clears the sticky flags.
- `generate_next_sample`  out  1  one-cycle request to all voices.
- `new_sample_generated`  out  1  one-cycle pulse when `sample_out` updates.
- `sample_out`  out  `SAMPLE_WIDTH`  mixed sample to the codec.
- `clip`  out  1  sticky: a saturation occurred.
- `missed`  out  1  sticky: a voice timed out.
- `underrun`  out  1  sticky: a frame arrived before the mix completed.

## Operation
- **Frame edge.** A frame edge is `new_frame` high while its registered previous value was low.
- **States.** The block has four states: `IDLE`, `WAIT`, `ACCUM`, `DONE`.
- **On every frame edge (any state):**
  - `sample_out` <= `pending`.
  - Pulse `new_sample_generated` and `generate_next_sample`.
  - Clear `got` and the latches, load the timeout counter, and go to `WAIT`.
- **Underrun.** If a frame edge arrives while in `WAIT` or `ACCUM`:
  - `pending` is left unchanged, so the previous sample repeats.
  - `underrun` is set.
  - The in-flight mix is discarded.
- **`WAIT`:**
  - For each i with `voice_ready[i]` high, latch the sample into `lat[i]` and set `got[i]`. Only the first ready per frame is taken.
  - Leave for `ACCUM` when `(got | ~voice_active)` is all ones, or when the counter reaches 0.
  - On timeout, active voices without `got` contribute 0 and `missed` is set.
- **`ACCUM`:**
  - Process one voice per cycle, index 0..`NUM_VOICES-1`.
  - `acc` += `lat[i]` if `voice_active[i] & got[i]`, else 0.
  - The accumulator is signed, `SAMPLE_WIDTH+4+4` bits wide, so it cannot overflow.
  - After the last voice, go to `DONE`.
- **`DONE`:**
  - Saturate `acc` to [-2^(W-1), 2^(W-1)-1] and write the result to `pending`.
  - Set `clip` if the value was clamped.
  - Go to `IDLE`.
- **`IDLE`.** Hold until the next frame edge.
- **Ready pulses outside `WAIT`** are ignored.
- **`clip_clear`.** Clears `clip`, `missed` and `underrun`. A set event in the same cycle wins.
- **All voices inactive.** `WAIT` exits on the next cycle and the mix yields 0.

## Timing
- Reset values: `sample_out`=0, `pending`=0, all flags 0, `generate_next_sample`=0, `new_sample_generated`=0, state `IDLE`.
- **Latency from frame edge (cycle E):** at E+1, `sample_out` is valid and both pulses are high.
- **Worst-case mix time:** `READY_TIMEOUT` + `NUM_VOICES` + 2 cycles after E+1. Frames must be spaced at least this far apart, otherwise an underrun occurs.
- A sample computed in frame k appears on `sample_out` at frame k+1.
- **Reset mid-mix:** discards the mix and returns every register to its reset value in the next cycle.

## Configuration
- **With `POLY_MIXER_GAIN_EN` defined:**
  - The `voice_gain` port exists.
  - In `ACCUM`, each term is `(lat[i] * gain_i) >>> 3`, an arithmetic shift that truncates toward negative infinity.
  - Gain 0 mutes the voice; gain 15 is 1.875x.
  - ACCUM timing is unchanged: one multiply per cycle.
- **Without it:** there is no `voice_gain` port, and each term is `lat[i]` (unity gain).

## Test plan
1. **Reset.** Assert `reset` for 2 cycles -> `sample_out`=0, all flags 0, no pulses.
2. **Basic mix.** `NUM_VOICES`=3, all voices active. Voices ready 3 cycles after the request with samples 1000, 2000, -500 -> at the next frame edge +1, `sample_out`=2500 and `new_sample_generated`=1 for exactly one cycle.
3. **Saturation and clip_clear.**
   - Samples 30000, 30000, 0 -> `sample_out`=32767, `clip`=1.
   - Samples -30000, -30000, 0 -> `sample_out`=-32768.
   - `clip_clear` -> `clip`=0.
4. **Timeout.** Voice 2 is active but never ready, `READY_TIMEOUT`=64, voices 0/1 give 100 and 200 -> `sample_out`=300 and `missed`=1. Masking voice 2 inactive instead gives 300 with `missed`=0.
5. **Underrun.** Frame edges 4 cycles apart with `READY_TIMEOUT`=64 and a silent voice -> `sample_out` repeats the prior value and `underrun`=1.
6. **Gain** (`POLY_MIXER_GAIN_EN`). Voice 0 sample 1000 with gain 4, voice 1 sample -1001 with gain 8 -> `sample_out`=500+(-1001)=-501.
